// File: rtl/pop_cat_controller_if.sv
// Tap handshake, raster position and sprite outputs shared between the tap
// logic, the video timing and the pop-cat controller.
interface pop_cat_controller_if #(
    parameter int COUNT_WIDTH = 16
) ();
    logic [10:0]            hcount_in;
    logic [9:0]             vcount_in;
    logic                   tap_valid_in;
    logic                   tap_ready_out;
    logic                   pop_out;
    logic [10:0]            x_out;
    logic [9:0]             y_out;
    logic [COUNT_WIDTH-1:0] pop_count_out;
    logic                   frame_tick_out;

    modport master (
        output hcount_in, vcount_in, tap_valid_in,
        input  tap_ready_out, pop_out, x_out, y_out, pop_count_out, frame_tick_out
    );

    modport slave (
        input  hcount_in, vcount_in, tap_valid_in,
        output tap_ready_out, pop_out, x_out, y_out, pop_count_out, frame_tick_out
    );
endinterface

// File: rtl/pop_cat_controller.sv
// Pop-cat sprite sequencer: queues at most one tap and applies it at the frame
// boundary, so every sprite-facing output changes only on the frame tick.
module pop_cat_controller #(
    parameter int HOLD_FRAMES = 6,
    parameter int V_ACTIVE    = 720,
    parameter int X_HOME      = 512,
    parameter int Y_HOME      = 232,
    parameter int SQUASH_PX   = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                 pixel_clk_in,
    input  logic                 rst_n_in,
    pop_cat_controller_if.slave  bus
);
    localparam int FL_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [FL_W-1:0]        FL_RELOAD  = FL_W'(HOLD_FRAMES - 1);
    localparam logic [9:0]             V_TICK     = 10'(V_ACTIVE);
    localparam logic [10:0]            X_HOME_V   = 11'(X_HOME);
    localparam logic [9:0]             Y_HOME_V   = 10'(Y_HOME);
    localparam logic [9:0]             Y_POP_V    = 10'(Y_HOME + SQUASH_PX);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX  = '1;

    typedef enum logic {
        IDLE,
        POPPED
    } state_t;

    state_t          state;
    logic            pending;
    logic [FL_W-1:0] frames_left;
    logic            tick;
    logic            accept;
    logic            apply;

    assign tick              = (bus.hcount_in == 11'd0) && (bus.vcount_in == V_TICK);
    assign bus.tap_ready_out = ~pending;
    assign accept            = bus.tap_valid_in & ~pending;
    // A tap accepted in the tick cycle itself is applied straight away.
    assign apply             = pending | accept;

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state              <= IDLE;
            pending            <= 1'b0;
            frames_left        <= '0;
            bus.pop_out        <= 1'b0;
            bus.x_out          <= X_HOME_V;
            bus.y_out          <= Y_HOME_V;
            bus.pop_count_out  <= '0;
            bus.frame_tick_out <= 1'b0;
        end else begin
            bus.frame_tick_out <= tick;
            bus.x_out          <= X_HOME_V;
            if (tick) begin
                // The tick always consumes the queued tap, if any.
                pending <= 1'b0;
                if (apply) begin
                    state       <= POPPED;
                    frames_left <= FL_RELOAD;
                    bus.pop_out <= 1'b1;
                    bus.y_out   <= Y_POP_V;
                    if (bus.pop_count_out != COUNT_MAX) begin
                        bus.pop_count_out <= bus.pop_count_out + 1'b1;
                    end
                end else if (state == POPPED && frames_left != '0) begin
                    frames_left <= frames_left - 1'b1;
                end else begin
                    state       <= IDLE;
                    bus.pop_out <= 1'b0;
                    bus.y_out   <= Y_HOME_V;
                end
            end else if (accept) begin
                pending <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pop_cat_controller.sv
// Randomized and directed bench for pop_cat_controller: two instances (default
// and a small-counter/wrapping-y variant) checked every cycle against a frame-level model.
module tb_pop_cat_controller;
    localparam int HOLD [2] = '{6, 2};
    localparam int XH   [2] = '{512, 2047};
    localparam int YH   [2] = '{232, 1020};
    localparam int CMAX [2] = '{65535, 3};
    localparam int SQ       = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] h;
    logic [9:0]  v;
    logic        valid;

    int n_cmp  = 0;
    int n_fail = 0;

    // Frame-level model: taps queued, frames of pop remaining, taps applied.
    bit m_pend [2];
    int m_left [2];
    int m_cnt  [2];
    bit m_ftick;

    always #5 clk = ~clk;

    pop_cat_controller_if #(.COUNT_WIDTH(16)) bus0 ();
    pop_cat_controller_if #(.COUNT_WIDTH(2))  bus1 ();

    assign bus0.hcount_in    = h;
    assign bus0.vcount_in    = v;
    assign bus0.tap_valid_in = valid;
    assign bus1.hcount_in    = h;
    assign bus1.vcount_in    = v;
    assign bus1.tap_valid_in = valid;

    pop_cat_controller #(
        .HOLD_FRAMES(6), .V_ACTIVE(720), .X_HOME(512), .Y_HOME(232),
        .SQUASH_PX(8), .COUNT_WIDTH(16)
    ) u_dut0 (
        .pixel_clk_in(clk), .rst_n_in(rst_n), .bus(bus0.slave)
    );

    pop_cat_controller #(
        .HOLD_FRAMES(2), .V_ACTIVE(720), .X_HOME(2047), .Y_HOME(1020),
        .SQUASH_PX(8), .COUNT_WIDTH(2)
    ) u_dut1 (
        .pixel_clk_in(clk), .rst_n_in(rst_n), .bus(bus1.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_y(input int i);
        return (m_left[i] > 0) ? (YH[i] + SQ) % 1024 : YH[i];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pend[i] = 1'b0;
            m_left[i] = 0;
            m_cnt[i]  = 0;
        end
        m_ftick = 1'b0;
    endtask

    task automatic model_step();
        bit tk;
        bit acc;
        bit ap;
        if (!rst_n) begin
            model_reset();
            return;
        end
        tk      = (h == 11'd0) && (v == 10'd720);
        m_ftick = tk;
        for (int i = 0; i < 2; i++) begin
            acc = valid && !m_pend[i];
            ap  = m_pend[i] || acc;
            if (tk) begin
                if (ap) begin
                    m_left[i] = HOLD[i];
                    if (m_cnt[i] < CMAX[i]) m_cnt[i]++;
                end else if (m_left[i] > 0) begin
                    m_left[i]--;
                end
                m_pend[i] = 1'b0;
            end else if (acc) begin
                m_pend[i] = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        check("ready0", 32'(bus0.tap_ready_out), 32'(!m_pend[0]));
        check("pop0",   32'(bus0.pop_out),       32'(m_left[0] > 0));
        check("x0",     32'(bus0.x_out),         XH[0]);
        check("y0",     32'(bus0.y_out),         exp_y(0));
        check("count0", 32'(bus0.pop_count_out), m_cnt[0]);
        check("ftick0", 32'(bus0.frame_tick_out), 32'(m_ftick));
        check("ready1", 32'(bus1.tap_ready_out), 32'(!m_pend[1]));
        check("pop1",   32'(bus1.pop_out),       32'(m_left[1] > 0));
        check("x1",     32'(bus1.x_out),         XH[1]);
        check("y1",     32'(bus1.y_out),         exp_y(1));
        check("count1", 32'(bus1.pop_count_out), m_cnt[1]);
        check("ftick1", 32'(bus1.frame_tick_out), 32'(m_ftick));
    endtask

    // One cycle: check outputs at the falling edge, then apply new inputs.
    task automatic drive(input logic [10:0] hh, input logic [9:0] vv, input logic vld);
        @(negedge clk);
        compare_all();
        h     = hh;
        v     = vv;
        valid = vld;
        model_step();
    endtask

    // Any raster position except the tick, biased towards near misses.
    task automatic drive_idle(input logic vld);
        logic [10:0] hh;
        logic [9:0]  vv;
        hh = 11'($urandom);
        vv = 10'($urandom);
        case ($urandom_range(0, 3))
            0:       vv = 10'd720;
            1:       hh = 11'd0;
            default: ;
        endcase
        if (hh == 11'd0 && vv == 10'd720) hh = 11'd1;
        drive(hh, vv, vld);
    endtask

    task automatic tick_cycle(input logic vld);
        drive(11'd0, 10'd720, vld);
    endtask

    // A short frame, optionally with a single tap; returns with post-tick outputs visible.
    task automatic frame_step(input logic tap);
        repeat (3) drive_idle(1'b0);
        if (tap) drive_idle(1'b1);
        drive_idle(1'b0);
        tick_cycle(1'b0);
        drive_idle(1'b0);
    endtask

    initial begin
        int pf;
        rst_n = 1'b0;
        h     = 11'd1;
        v     = 10'd0;
        valid = 1'b0;
        model_reset();
        repeat (3) drive_idle(1'b0);
        rst_n = 1'b1;
        repeat (2) drive_idle(1'b0);

        // Single tap mid-frame.
        drive(11'd5, 10'd100, 1'b1);
        drive_idle(1'b0);
        check("t2_ready_after_tap", 32'(bus0.tap_ready_out), 0);
        tick_cycle(1'b0);
        drive_idle(1'b0);
        check("t2_pop", 32'(bus0.pop_out), 1);
        check("t2_y", 32'(bus0.y_out), 240);
        check("t2_count", 32'(bus0.pop_count_out), 1);
        pf = 1;
        repeat (12) begin
            frame_step(1'b0);
            if (bus0.pop_out) pf++;
        end
        check("t2_hold_frames", pf, 6);

        // Tap in the tick cycle itself.
        drive_idle(1'b0);
        tick_cycle(1'b1);
        drive_idle(1'b0);
        check("t3_pop", 32'(bus0.pop_out), 1);
        check("t3_ready", 32'(bus0.tap_ready_out), 1);
        check("t3_count", 32'(bus0.pop_count_out), 2);
        repeat (8) frame_step(1'b0);

        // Retrigger during frame 4 of the hold.
        frame_step(1'b1);
        pf = bus0.pop_out ? 1 : 0;
        repeat (3) begin
            frame_step(1'b0);
            if (bus0.pop_out) pf++;
        end
        frame_step(1'b1);
        if (bus0.pop_out) pf++;
        repeat (12) begin
            frame_step(1'b0);
            if (bus0.pop_out) pf++;
        end
        check("t4_hold_frames", pf, 10);
        check("t4_count", 32'(bus0.pop_count_out), 4);

        // Two taps in one frame: the second is held off until the tick.
        drive_idle(1'b1);
        drive_idle(1'b1);
        check("t5_held_off", 32'(bus0.tap_ready_out), 0);
        drive_idle(1'b1);
        tick_cycle(1'b1);
        drive_idle(1'b1);
        drive_idle(1'b0);
        check("t5_second_pending", 32'(bus0.tap_ready_out), 0);
        check("t5_count_mid", 32'(bus0.pop_count_out), 5);
        frame_step(1'b0);
        check("t5_count", 32'(bus0.pop_count_out), 6);
        check("t6_count_saturated", 32'(bus1.pop_count_out), 3);
        repeat (8) frame_step(1'b0);

        // Stalled timing: pending holds until a tick finally arrives.
        drive_idle(1'b1);
        repeat (40) drive_idle(1'b0);
        check("stall_ready", 32'(bus0.tap_ready_out), 0);
        tick_cycle(1'b0);
        drive_idle(1'b0);
        check("stall_ready_after_tick", 32'(bus0.tap_ready_out), 1);
        check("y_wrap", 32'(bus1.y_out), 4);
        check("x_home_max", 32'(bus1.x_out), 2047);
        repeat (8) frame_step(1'b0);

        repeat (3000) begin
            if ($urandom_range(0, 15) == 0) tick_cycle($urandom_range(0, 3) == 0);
            else drive_idle($urandom_range(0, 7) == 0);
        end

        // Asynchronous reset in the middle of a hold.
        frame_step(1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t1_pop", 32'(bus0.pop_out), 0);
        check("t1_y", 32'(bus0.y_out), 232);
        check("t1_count", 32'(bus0.pop_count_out), 0);
        check("t1_ready", 32'(bus0.tap_ready_out), 1);
        model_reset();
        repeat (2) drive_idle(1'b0);
        rst_n = 1'b1;
        repeat (3) drive_idle(1'b0);
        frame_step(1'b1);
        check("post_reset_count", 32'(bus0.pop_count_out), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
